corner_align_delay: RTL and testbench
=====================================

# corner_align_delay

Parametrised, frame-aware delay line that re-aligns the per-pixel corner result (flag plus optional score bits) from the Harris stage with the centre pixel of the WIN×WIN descriptor window. Delay is derived from image width, window size and upstream latency instead of a hand-computed constant. It adds start-of-frame tracking so stale results from the previous frame are flagged and optionally masked. It sits between the corner detector and the ORB descriptor/orientation stage.

## Interface
- WIDTH, 1: payload bits per pixel (bit 0 = corner flag; upper bits = score).
- IMG_W, 640: pixels per image line.
- WIN, 37: descriptor window side, odd, ≥3.
- LATENCY, 0: upstream corner-detector latency in enabled cycles.
- MASK_INVALID, 1: 1 = force dout to 0 while dout_valid is low; 0 = pass raw buffer data.
- Derived: HALF = (WIN-1)/2; DELAY = HALF*(IMG_W-1) - LATENCY (defaults give 11502); ADDR_W = clog2(DELAY-1).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  pixel enable; all state advances only on edges with ena=1.
- sof  in  1  start of frame; qualifies the din sample on the same enabled edge.
- din  in  WIDTH  corner payload for the current pixel.
- dout  out  WIDTH  payload delayed by DELAY enabled edges.
- dout_valid  out  1  dout belongs to the current frame.

## Operation
- Circular buffer: write pointer 0..DELAY-2, wraps to 0. On each enabled edge, read the old entry at the pointer and write din. The read data is registered into dout. Total delay is exactly DELAY enabled edges.
- Fill counter (width ADDR_W+1, saturates at DELAY):
  - On an enabled edge with sof=1, the counter loads 1.
  - Otherwise, on an enabled edge, it increments until DELAY.
  - Reset loads 0, so reset behaves as an implicit frame start with an empty buffer.
- dout_valid, updated on enabled edges:
  - sof=1 → 0.
  - Otherwise → (counter value before the edge ≥ DELAY).
- MASK_INVALID=1: dout register loads 0 whenever the new dout_valid is 0. MASK_INVALID=0: dout always loads buffer data.
- Buffer contents are never cleared; masking handles stale data.
- ena=0: pointer, counter, dout and dout_valid hold. sof is ignored when ena=0.
- Elaboration error if WIN is even, WIN<3, or DELAY<2.

## Timing
- Reset (async assert, sync-safe deassert by the environment): dout=0, dout_valid=0, pointer=0, counter=0, immediately on rst rising, including mid-frame.
- Latency: the din presented at enabled edge k appears on dout after enabled edge k+DELAY.
- sof at enabled edge s:
  - dout_valid is 0 after edges s..s+DELAY-1.
  - dout_valid is 1 after edge s+DELAY, showing the sof sample.
- A second sof before the buffer fills restarts the count; there is no carry-over.
- Pointer wrap from DELAY-2 to 0 causes no bubble.

## Structure
- Package corner_align_pkg holds:
  - function calc_delay(IMG_W, WIN, LATENCY);
  - clog2 function;
  - the payload bit-field constants (CORNER_BIT=0, SCORE_LSB=1).
- Sub-module ring_ram: simple dual-port RAM, DEPTH=DELAY-1, width WIDTH, synchronous read-before-write on the same address, with a clock enable. It must infer block RAM.
- Top level holds the pointer, fill counter, valid logic, masking mux and the output register.

## Test plan
Bench parameters: IMG_W=8, WIN=5, LATENCY=3, giving DELAY=11.

1. Ramp with sof at edge 0, din=n at enabled edge n, ena=1 always → after edge 11: dout=0, dout_valid=1. After edge n≥11: dout=n-11. After edges 0..10: dout=0, valid=0.
2. ena pattern 1,0,0,1 repeating, with the same ramp → dout changes only on enabled edges. Delay stays 11 enabled edges. Outputs hold stable across ena=0 cycles.
3. sof again at edge 20 → dout_valid=0 and dout=0 after edges 20..30; after edge 31, dout=20 and dout_valid=1.
4. MASK_INVALID=0, same stimulus as test 3 → dout=n-11 continuously (9..19 during edges 20..30) while dout_valid=0.
5. rst pulsed asynchronously at edge 15 mid-cycle → dout=0 and dout_valid=0 before the next clock edge. After release, with sof at edge r, valid first rises at edge r+11.
6. Default parameters → DELAY elaborates to 11502. A single corner pulse din=1 at edge 0 with sof emerges with dout=1, dout_valid=1 after edge 11502 only.

Source files
------------

// File: rtl/corner_align_pkg.sv
// Shared constants and elaboration helpers for the corner-result alignment delay.
package corner_align_pkg;

  // Payload bit fields: bit 0 is the corner flag, the bits above it carry the score.
  localparam int unsigned CORNER_BIT = 0;
  localparam int unsigned SCORE_LSB  = 1;

  // Pixels between the detector output and the window centre, minus upstream latency.
  function automatic int calc_delay(input int img_w, input int win, input int latency);
    return ((win - 1) / 2) * (img_w - 1) - latency;
  endfunction

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ring_ram.sv
// Simple dual-port RAM with synchronous read-before-write and a shared clock enable.
module ring_ram #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 1
) (
  input  logic              clk,
  input  logic              ce,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset on storage or read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (ce) begin
      rd_data      <= mem[rd_addr];
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/corner_align_delay.sv
// Frame-aware delay line aligning corner results with the descriptor window centre.
module corner_align_delay
  import corner_align_pkg::*;
#(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned IMG_W        = 640,
  parameter int unsigned WIN          = 37,
  parameter int unsigned LATENCY      = 0,
  parameter bit          MASK_INVALID = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             sof,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  localparam int          DELAY_I = calc_delay(int'(IMG_W), int'(WIN), int'(LATENCY));
  localparam int unsigned DELAY   = (DELAY_I < 2) ? 32'd2 : 32'(DELAY_I);
  localparam int unsigned DEPTH   = DELAY - 1;
  localparam int unsigned ADDR_W  = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam int unsigned CNT_W   = ADDR_W + 1;

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DELAY);

  if (((WIN % 2) == 0) || (WIN < 3) || (DELAY_I < 2)) begin : g_param_err
    $error("corner_align_delay: WIN must be odd and >= 3, and DELAY must be >= 2");
  end

  logic [ADDR_W-1:0] wr_ptr;
  logic [CNT_W-1:0]  fill_cnt;
  logic [WIDTH-1:0]  ram_rdata;
  logic              valid_next;
  logic [WIDTH-1:0]  dout_next;

  // The RAM read register plus the dout register give DEPTH + 1 = DELAY edges.
  ring_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ring_ram (
    .clk     (clk),
    .ce      (ena),
    .wr_addr (wr_ptr),
    .wr_data (din),
    .rd_addr (wr_ptr),
    .rd_data (ram_rdata)
  );

  // Valid needs DELAY samples of the current frame already in the pipe.
  always_comb begin
    valid_next = 1'b0;
    dout_next  = ram_rdata;
    if (!sof) valid_next = (fill_cnt >= CNT_FULL);
    if (MASK_INVALID && !valid_next) dout_next = '0;
  end

  // Reset doubles as a frame start with an empty buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (ena) begin
      wr_ptr     <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + ADDR_W'(1);
      if (sof)
        fill_cnt <= CNT_W'(1);
      else if (fill_cnt < CNT_FULL)
        fill_cnt <= fill_cnt + CNT_W'(1);
      dout       <= dout_next;
      dout_valid <= valid_next;
    end
  end

endmodule

// File: tb/tb_corner_align_delay.sv
// Bench for corner_align_delay: masked, unmasked and default-parameter instances against a history model.
module tb_corner_align_delay;

  localparam int D     = 11;
  localparam int D_DEF = 11502;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       sof;
  logic [7:0] din;
  logic [7:0] dout_a;
  logic       valid_a;
  logic [7:0] dout_b;
  logic       valid_b;
  logic [0:0] dout_c;
  logic       valid_c;

  int checks = 0;
  int errors = 0;

  corner_align_delay #(.WIDTH(8), .IMG_W(8), .WIN(5), .LATENCY(3), .MASK_INVALID(1'b1)) dut_mask (
    .clk(clk), .rst(rst), .ena(ena), .sof(sof), .din(din), .dout(dout_a), .dout_valid(valid_a));

  corner_align_delay #(.WIDTH(8), .IMG_W(8), .WIN(5), .LATENCY(3), .MASK_INVALID(1'b0)) dut_raw (
    .clk(clk), .rst(rst), .ena(ena), .sof(sof), .din(din), .dout(dout_b), .dout_valid(valid_b));

  corner_align_delay dut_def (
    .clk(clk), .rst(rst), .ena(ena), .sof(sof), .din(din[0:0]), .dout(dout_c), .dout_valid(valid_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: every enabled sample since reset, plus the index of the current frame start.
  int hist [0:16383];
  int cnt;
  int fstart;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 0;
      fstart <= 0;
    end else if (ena) begin
      hist[cnt] <= int'(din);
      if (sof) fstart <= cnt;
      cnt <= cnt + 1;
    end
  end

  function automatic void model(input int d, input bit mask, output bit known,
                                output int exp_dout, output bit exp_valid);
    int e;
    known     = 1'b1;
    exp_dout  = 0;
    exp_valid = 1'b0;
    if (cnt > 0) begin
      e         = cnt - 1;
      exp_valid = ((e - fstart) >= d);
      if (mask)
        exp_dout = exp_valid ? hist[e - d] : 0;
      else if (e >= d)
        exp_dout = hist[e - d];
      else
        known = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    bit k;
    int ed;
    bit ev;
    model(D, 1'b1, k, ed, ev);
    chk("dout_mask", 32'(dout_a), ed);
    chk("valid_mask", 32'(valid_a), int'(ev));
    model(D, 1'b0, k, ed, ev);
    if (k) chk("dout_raw", 32'(dout_b), ed);
    chk("valid_raw", 32'(valid_b), int'(ev));
    model(D_DEF, 1'b1, k, ed, ev);
    chk("dout_def", 32'(dout_c), ed & 1);
    chk("valid_def", 32'(valid_c), int'(ev));
  end

  task automatic tick(input bit e, input bit s, input int d);
    ena = e;
    sof = s;
    din = 8'(d);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0, 0);
    rst = 1'b0;
  endtask

  initial begin
    int k;
    bit en;
    rst = 1'b1;
    ena = 1'b0;
    sof = 1'b0;
    din = '0;
    repeat (3) tick(1'b0, 1'b0, 0);
    chk("lit_reset_dout", 32'(dout_a), 0);
    chk("lit_reset_valid", 32'(valid_a), 0);
    rst = 1'b0;

    // Ramp with frame starts at edges 0 and 20, ena always high.
    for (int n = 0; n < 45; n++) begin
      tick(1'b1, (n == 0) || (n == 20), n);
      if (n == 10) begin
        chk("lit_e10_valid", 32'(valid_a), 0);
        chk("lit_e10_dout", 32'(dout_a), 0);
      end
      if (n == 11) begin
        chk("lit_e11_valid", 32'(valid_a), 1);
        chk("lit_e11_dout", 32'(dout_a), 0);
      end
      if (n == 19) chk("lit_e19_dout", 32'(dout_a), 8);
      if (n == 20) chk("lit_e20_valid", 32'(valid_a), 0);
      if (n == 25) begin
        chk("lit_e25_raw_dout", 32'(dout_b), 14);
        chk("lit_e25_raw_valid", 32'(valid_b), 0);
      end
      if (n == 30) chk("lit_e30_valid", 32'(valid_a), 0);
      if (n == 31) begin
        chk("lit_e31_dout", 32'(dout_a), 20);
        chk("lit_e31_valid", 32'(valid_a), 1);
      end
    end

    // Sparse enable 1,0,0,1 with a ramp on enabled edges; filler data when disabled.
    pulse_reset();
    k = 0;
    while (k < 16) begin
      en = ((k % 2) == 0) ? 1'b1 : 1'b1;
      tick(1'b1, k == 0, k);
      k++;
      if (k < 16) begin
        tick(1'b0, 1'b1, 8'hAA);
        tick(1'b0, 1'b0, 8'h55);
        if (k == 14) chk("lit_hold_dout", 32'(dout_a), 2);
      end
    end
    chk("lit_e15_dout", 32'(dout_a), 4);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    chk("lit_async_dout", 32'(dout_a), 0);
    chk("lit_async_valid", 32'(valid_a), 0);
    chk("lit_async_raw_dout", 32'(dout_b), 0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Frame start at edge 3 after reset.
    for (int n = 0; n < 21; n++) begin
      tick(1'b1, n == 3, 100 + n);
      if (n == 13) chk("lit_r13_valid", 32'(valid_a), 0);
      if (n == 14) begin
        chk("lit_r14_valid", 32'(valid_a), 1);
        chk("lit_r14_dout", 32'(dout_a), 103);
      end
    end

    // Default parameters: single corner pulse through the full-size line.
    pulse_reset();
    for (int n = 0; n < 11506; n++) begin
      tick(1'b1, n == 0, (n == 0) ? 1 : 0);
      if (n == 11501) begin
        chk("lit_def_pre_dout", 32'(dout_c), 0);
        chk("lit_def_pre_valid", 32'(valid_c), 0);
      end
      if (n == 11502) begin
        chk("lit_def_dout", 32'(dout_c), 1);
        chk("lit_def_valid", 32'(valid_c), 1);
      end
      if (n == 11503) chk("lit_def_post_dout", 32'(dout_c), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
